// File: rtl/dma_copy_pkg.sv
// Shared definitions for the dma_copy block: register indices, CTRL/STATUS
// bit positions, the transfer FSM state type and the word step.
package dma_copy_pkg;

  localparam int unsigned DATA_W = 32;

  // Register map (word index on i_address)
  localparam logic [1:0] REG_SRC   = 2'd0;
  localparam logic [1:0] REG_DST   = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  // CTRL write bits
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_ABORT    = 3;

  // STATUS read bits
  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_IRQ_EN  = 2;
  localparam int unsigned ST_ABORTED = 3;

  localparam logic [DATA_W-1:0] WORD_STEP = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_GAP,
    WR_REQ,
    WR_GAP,
    FINISH
  } state_t;

endpackage

// File: rtl/dma_copy_if.sv
// Signal bundle for dma_copy: the register responder port (i_request .. o_ready)
// and the CPU-bus initiator port (o_bus_request .. i_bus_ready).
// slave  : the view taken by dma_copy itself.
// master : the view taken by the surrounding system (CPU + bus).
interface dma_copy_if;
  import dma_copy_pkg::*;

  logic              i_request;
  logic              i_rw;
  logic [1:0]        i_address;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] o_rdata;
  logic              o_ready;

  logic              o_bus_request;
  logic              o_bus_rw;
  logic [DATA_W-1:0] o_bus_address;
  logic [DATA_W-1:0] o_bus_wdata;
  logic [DATA_W-1:0] i_bus_rdata;
  logic              i_bus_ready;

  modport slave (
    input  i_request, i_rw, i_address, i_wdata, i_bus_rdata, i_bus_ready,
    output o_rdata, o_ready, o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata
  );

  modport master (
    output i_request, i_rw, i_address, i_wdata, i_bus_rdata, i_bus_ready,
    input  o_rdata, o_ready, o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata
  );
endinterface

// File: rtl/dma_copy_fifo.sv
// Staging buffer for dma_copy: synchronous FIFO, 32-bit words, DEPTH entries.
// Ports: i_clock, i_reset_n (sync, active-low), push/pop requests, flush
// (empties the FIFO, wins over push/pop), wdata in, rdata = current head,
// full/empty derived from an occupancy counter.
module dma_copy_fifo
  import dma_copy_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     occ;
  logic              do_push;
  logic              do_pop;

  assign full    = (occ == CW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Explicit wrap keeps non-full-range pointers (DEPTH=1) inside the array.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_copy.sv
// Memory-to-memory copy engine. Software programs SRC/DST/COUNT through the
// register responder, starts via CTRL, and the engine moves COUNT words by
// reading up to BUFFER_DEPTH words into a staging FIFO, then writing them out.
// Ports: i_clock, i_reset_n (sync, active-low), io (dma_copy_if.slave: register
// responder + bus initiator), o_interrupt (DONE & IRQ_EN, level).
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  dma_copy_if.slave  io,
  output logic       o_interrupt
);

  state_t            state;
  logic [DATA_W-1:0] src, dst, count;
  logic              busy, done, irq_en, aborted, abort_pend;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              reg_wr, ctrl_wr, start_req, abort_req, abort_now, abort_fire;

  // A register access is taken once, on the first cycle i_request is seen.
  assign reg_wr    = io.i_request && !io.o_ready && io.i_rw;
  assign ctrl_wr   = reg_wr && (io.i_address == REG_CTRL);
  assign abort_req = ctrl_wr && io.i_wdata[CTRL_ABORT];
  assign start_req = ctrl_wr && io.i_wdata[CTRL_START] && !io.i_wdata[CTRL_ABORT];
  assign abort_now = busy && (abort_pend || abort_req);

  assign fifo_push = (state == RD_REQ) && io.i_bus_ready;
  assign fifo_pop  = (state == WR_REQ) && io.i_bus_ready;

  assign o_interrupt = done && irq_en;

  // Abort takes effect only at a point with no handshake in flight.
  always_comb begin
    abort_fire = 1'b0;
    if (abort_now) begin
      case (state)
        RD_REQ, WR_REQ:         abort_fire = io.i_bus_ready;
        RD_GAP, WR_GAP, FINISH: abort_fire = 1'b1;
        default:                abort_fire = 1'b0;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (io.i_address)
      REG_SRC:   rd_mux = src;
      REG_DST:   rd_mux = dst;
      REG_COUNT: rd_mux = count;
      default: begin
        rd_mux[ST_BUSY]    = busy;
        rd_mux[ST_DONE]    = done;
        rd_mux[ST_IRQ_EN]  = irq_en;
        rd_mux[ST_ABORTED] = aborted;
      end
    endcase
  end

  dma_copy_fifo #(.DEPTH(BUFFER_DEPTH)) u_fifo (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (abort_fire),
    .wdata     (io.i_bus_rdata),
    .rdata     (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state            <= IDLE;
      src              <= '0;
      dst              <= '0;
      count            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      irq_en           <= 1'b0;
      aborted          <= 1'b0;
      abort_pend       <= 1'b0;
      io.o_ready       <= 1'b0;
      io.o_rdata       <= '0;
      io.o_bus_request <= 1'b0;
      io.o_bus_rw      <= 1'b0;
      io.o_bus_address <= '0;
      io.o_bus_wdata   <= '0;
    end else begin
      io.o_ready <= io.i_request;
      io.o_rdata <= io.i_request ? rd_mux : '0;

      if (reg_wr) begin
        case (io.i_address)
          REG_SRC:   if (!busy) src   <= io.i_wdata;
          REG_DST:   if (!busy) dst   <= io.i_wdata;
          REG_COUNT: if (!busy) count <= io.i_wdata;
          default: begin
            irq_en <= io.i_wdata[CTRL_IRQ_EN];
            if (io.i_wdata[CTRL_CLR_DONE]) done <= 1'b0;
          end
        endcase
      end

      if (abort_req && busy) abort_pend <= 1'b1;

      if (fifo_push) begin
        src   <= src + WORD_STEP;
        count <= count - 1'b1;
      end
      if (fifo_pop) dst <= dst + WORD_STEP;

      case (state)
        IDLE: begin
          if (start_req) begin
            done    <= 1'b0;
            aborted <= 1'b0;
            busy    <= 1'b1;
            if (count != '0) begin
              state            <= RD_REQ;
              io.o_bus_request <= 1'b1;
              io.o_bus_rw      <= 1'b0;
              io.o_bus_address <= src;
            end else begin
              state <= FINISH;
            end
          end
        end
        RD_REQ: begin
          if (io.i_bus_ready) begin
            io.o_bus_request <= 1'b0;
            state            <= RD_GAP;
          end
        end
        RD_GAP: begin
          io.o_bus_request <= 1'b1;
          if (!fifo_full && count != '0) begin
            state            <= RD_REQ;
            io.o_bus_rw      <= 1'b0;
            io.o_bus_address <= src;
          end else begin
            state            <= WR_REQ;
            io.o_bus_rw      <= 1'b1;
            io.o_bus_address <= dst;
            io.o_bus_wdata   <= fifo_head;
          end
        end
        WR_REQ: begin
          if (io.i_bus_ready) begin
            io.o_bus_request <= 1'b0;
            state            <= WR_GAP;
          end
        end
        WR_GAP: begin
          if (!fifo_empty) begin
            state            <= WR_REQ;
            io.o_bus_request <= 1'b1;
            io.o_bus_rw      <= 1'b1;
            io.o_bus_address <= dst;
            io.o_bus_wdata   <= fifo_head;
          end else if (count != '0) begin
            state            <= RD_REQ;
            io.o_bus_request <= 1'b1;
            io.o_bus_rw      <= 1'b0;
            io.o_bus_address <= src;
          end else begin
            state <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Overrides whatever the state step chose above.
      if (abort_fire) begin
        state            <= IDLE;
        busy             <= 1'b0;
        done             <= 1'b0;
        aborted          <= 1'b1;
        abort_pend       <= 1'b0;
        io.o_bus_request <= 1'b0;
      end
    end
  end

endmodule
